muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. Operands come straight from the register file read ports (rs on rd1, rt on rd2). Results land in HI/LO, which MFHI/MFLO route back to the register file write-data mux. The unit runs for 33 cycles per operation and raises `busy` so control can stall the PC on a dependent instruction.

---
 rtl/muldiv_unit.sv | 112 +++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32x32 multiply/divide unit with HI/LO registers
// Magnitude-based shift-add multiply and restoring divide, sign fix-up in a final cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        is_div_q;
    logic        sa_q, sb_q;
    logic [31:0] mb_q;
    logic [63:0] p_q, p_d;
    logic [31:0] hi_q, lo_q;
    logic        busy_q, done_q;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_trial, div_diff;
    logic        div_ge, neg_res;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    always_comb begin
        a_neg     = ~op[0] & a[31];
        b_neg     = ~op[0] & b[31];
        a_mag     = a_neg ? (~a + 32'd1) : a;
        b_mag     = b_neg ? (~b + 32'd1) : b;
        // p_q holds {accumulator, multiplier} for multiply, {remainder, dividend/quotient} for divide
        mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, mb_q} : 33'd0);
        div_trial = {p_q[63:32], p_q[31]};
        div_ge    = (div_trial >= {1'b0, mb_q});
        div_diff  = div_trial - {1'b0, mb_q};
        p_d       = is_div_q ? {(div_ge ? div_diff[31:0] : div_trial[31:0]), p_q[30:0], div_ge}
                             : {mul_sum, p_q[31:1]};
        neg_res   = sa_q ^ sb_q;
        prod_fix  = neg_res ? (~p_q + 64'd1) : p_q;
        // divisor of zero yields all-ones quotient; remainder already equals the dividend
        quot_fix  = (mb_q == 32'd0) ? 32'hFFFF_FFFF
                                    : (neg_res ? (~p_q[31:0] + 32'd1) : p_q[31:0]);
        rem_fix   = sa_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            mb_q     <= 32'd0;
            p_q      <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= 5'd0;
                        is_div_q <= op[1];
                        sa_q     <= a_neg;
                        sb_q     <= b_neg;
                        mb_q     <= op[1] ? b_mag : a_mag;
                        p_q      <= {32'd0, (op[1] ? a_mag : b_mag)};
                    end else begin
                        if (hi_we) hi_q <= a;
                        if (lo_we) lo_q <= a;
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= FIX;
                end
                FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
